booth_divider: RTL and testbench

- Sequential signed divider that inverts the 3-bit Booth multiplier. It takes a 6-bit signed dividend (a product word) and a 3-bit signed divisor, and returns a signed quotient and remainder.
- Implemented as a start/busy/done controller around a restoring radix-2 datapath on magnitudes, followed by a sign-fix step.
- Sits beside the multiplier on the same operand buses. Its result words have the same widths as the multiplier operand and product words.

---
 rtl/booth_divider_if.sv | 26 ++
 rtl/booth_divider.sv | 107 ++++++++++
 tb/tb_booth_divider.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_divider_if.sv
// Operand/result bundle shared by the Booth divider and whatever drives it.
// The master issues start with operands; the slave returns the status and result words.
interface booth_divider_if #(
   parameter int DW = 6,
   parameter int VW = 3
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;
   logic          ovf;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero, ovf
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero, ovf
   );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring radix-2 on magnitudes, then a sign-fix cycle.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module booth_divider #(
   parameter int DW = 6,
   parameter int VW = 3
) (
   input logic             clk,
   input logic             rst,
   booth_divider_if.slave  bus
);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] dq;         // dividend magnitude, shifts out as quotient bits shift in
   logic [VW-1:0] dvm;
   logic [VW:0]   pr;
   logic [CW-1:0] cnt;
   logic          dvd_neg;
   logic          sign_diff;

   logic [DW-1:0] dvd_mag;
   logic [VW-1:0] dvs_mag;
   logic [VW:0]   pr_sh;
   logic [VW+1:0] trial;
   logic [DW-1:0] q_fix;
   logic [VW-1:0] r_fix;

   // The most negative input maps to its unsigned magnitude (|-32| = 32, |-4| = 4).
   assign dvd_mag = bus.dividend[DW-1] ? (~bus.dividend + DW'(1)) : bus.dividend;
   assign dvs_mag = bus.divisor[VW-1]  ? (~bus.divisor  + VW'(1)) : bus.divisor;

   assign pr_sh = {pr[VW-1:0], dq[DW-1]};
   assign trial = {1'b0, pr_sh} - {2'b00, dvm};
   assign q_fix = sign_diff ? (~dq + DW'(1)) : dq;
   assign r_fix = dvd_neg ? (~pr[VW-1:0] + VW'(1)) : pr[VW-1:0];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : ITER;
         ITER: if (cnt == CW'(1)) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dq            <= '0;
         dvm           <= '0;
         pr            <= '0;
         cnt           <= '0;
         dvd_neg       <= 1'b0;
         sign_diff     <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.div_zero  <= 1'b0;
         bus.ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               dvd_neg   <= bus.dividend[DW-1];
               sign_diff <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
               dq        <= dvd_mag;
               dvm       <= dvs_mag;
               pr        <= '0;
               cnt       <= CW'(DW);
               bus.ovf   <= 1'b0;
               if (bus.divisor == '0) begin
                  bus.div_zero  <= 1'b1;
                  bus.quotient  <= '0;
                  bus.remainder <= bus.dividend[VW-1:0];
               end else begin
                  bus.div_zero  <= 1'b0;
               end
            end
            ITER: begin
               dq  <= {dq[DW-2:0], ~trial[VW+1]};
               pr  <= trial[VW+1] ? pr_sh : trial[VW:0];
               cnt <= cnt - CW'(1);
            end
            FIX: begin
               bus.quotient  <= q_fix;
               bus.remainder <= r_fix;
               // Only -32/-1 lands here: positive result whose magnitude needs the sign bit.
               bus.ovf       <= ~sign_diff & dq[DW-1];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_divider.sv
// Directed and exhaustive checks of booth_divider: latency, signs, divide-by-zero,
// overflow, start-while-busy and reset abort.
module tb_booth_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   booth_divider_if #(.DW(6), .VW(3)) bus ();

   booth_divider #(.DW(6), .VW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Present one start for a single cycle and wait for done. lat counts edges
   // from the sampling edge (1) to the edge after which done is seen; -1 on timeout.
   task automatic do_op(input logic [5:0] a, input logic [2:0] b,
                        output int lat, output int busy_n);
      @(negedge clk);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk);
      lat    = 1;
      busy_n = 0;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      while (!bus.done && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.busy) busy_n++;
      end
      if (!bus.done) lat = -1;
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      #3;
      total++;
      if ({bus.busy, bus.done, bus.div_zero, bus.ovf, bus.quotient, bus.remainder} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b done=%b dz=%b ovf=%b q=%h r=%h want all 0",
                  bus.busy, bus.done, bus.div_zero, bus.ovf, bus.quotient, bus.remainder);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int lat, bn;
      do_op(6'd16, 3'b100, lat, bn);
      total++;
      if (lat !== 8) begin bad++; $display("FAIL basic_latency got %0d want 8", lat); end
      total++;
      if (bn !== 8) begin bad++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
      total++;
      if ({bus.quotient, bus.remainder, bus.ovf, bus.div_zero} !== {6'b111100, 3'd0, 2'b00}) begin
         bad++;
         $display("FAIL basic_16_div_m4 got q=%h r=%h ovf=%b dz=%b want q=3c r=0 ovf=0 dz=0",
                  bus.quotient, bus.remainder, bus.ovf, bus.div_zero);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_signs;
      logic [5:0] a_v [3] = '{6'b110011, 6'd31, 6'b111010};   // -13, 31, -6
      logic [2:0] b_v [3] = '{3'd3, 3'd2, 3'b100};             // 3, 2, -4
      logic [5:0] q_v [3] = '{6'b111100, 6'd15, 6'd1};         // -4, 15, 1
      logic [2:0] r_v [3] = '{3'b111, 3'd1, 3'b110};           // -1, 1, -2
      int lat, bn;
      for (int i = 0; i < 3; i++) begin
         do_op(a_v[i], b_v[i], lat, bn);
         total++;
         if (lat !== 8 || bus.quotient !== q_v[i] || bus.remainder !== r_v[i] || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL signs_%0d got lat=%0d q=%h r=%h ovf=%b want lat=8 q=%h r=%h ovf=0",
                     i, lat, bus.quotient, bus.remainder, bus.ovf, q_v[i], r_v[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      int lat, bn;
      do_op(6'd7, 3'd0, lat, bn);
      total++;
      if (lat !== 1) begin bad++; $display("FAIL divzero_latency got %0d want 1", lat); end
      total++;
      if ({bus.div_zero, bus.ovf, bus.quotient, bus.remainder} !== {2'b10, 6'd0, 3'b111}) begin
         bad++;
         $display("FAIL divzero_result got dz=%b ovf=%b q=%h r=%h want dz=1 ovf=0 q=0 r=7",
                  bus.div_zero, bus.ovf, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_ovf;
      int lat, bn;
      do_op(6'b100000, 3'b111, lat, bn);
      total++;
      if ({bus.ovf, bus.quotient, bus.remainder} !== {1'b1, 6'b100000, 3'd0} || lat !== 8) begin
         bad++;
         $display("FAIL ovf_m32_div_m1 got lat=%0d ovf=%b q=%h r=%h want lat=8 ovf=1 q=20 r=0",
                  lat, bus.ovf, bus.quotient, bus.remainder);
      end
      do_op(6'd9, 3'd3, lat, bn);
      total++;
      if ({bus.ovf, bus.quotient, bus.remainder} !== {1'b0, 6'd3, 3'd0}) begin
         bad++;
         $display("FAIL ovf_clear_9_div_3 got ovf=%b q=%h r=%h want ovf=0 q=3 r=0",
                  bus.ovf, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_ignore_start;
      int lat = 1;
      @(negedge clk);
      bus.dividend = 6'd12; bus.divisor = 3'd3; bus.start = 1'b1;
      @(posedge clk);                       // edge 1
      @(negedge clk); bus.start = 1'b0;
      @(posedge clk); lat++;                // edge 2
      @(negedge clk);
      bus.dividend = 6'd5; bus.divisor = 3'd1; bus.start = 1'b1;
      @(posedge clk); lat++;                // edge 3: ignored
      @(negedge clk); bus.start = 1'b0;
      while (!bus.done && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      total++;
      if (lat !== 8 || bus.quotient !== 6'd4 || bus.remainder !== 3'd0) begin
         bad++;
         $display("FAIL ignore_start got lat=%0d q=%h r=%h want lat=8 q=4 r=0",
                  lat, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_reset_abort;
      int lat, bn, seen = 0;
      @(negedge clk);
      bus.dividend = 6'd20; bus.divisor = 3'd3; bus.start = 1'b1;
      @(posedge clk);                       // edge 1
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(posedge clk);            // edge 4
      #1 rst = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.done, bus.div_zero, bus.ovf, bus.quotient, bus.remainder} !== 13'd0) begin
         bad++;
         $display("FAIL abort_outputs got busy=%b done=%b dz=%b ovf=%b q=%h r=%h want all 0",
                  bus.busy, bus.done, bus.div_zero, bus.ovf, bus.quotient, bus.remainder);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
      do_op(6'd10, 3'd3, lat, bn);
      total++;
      if (lat !== 8 || bus.quotient !== 6'd3 || bus.remainder !== 3'd1) begin
         bad++;
         $display("FAIL abort_restart got lat=%0d q=%h r=%h want lat=8 q=3 r=1",
                  lat, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_sweep;
      logic signed [5:0] sa;
      logic signed [2:0] sb;
      logic [5:0] eq;
      logic [2:0] er;
      logic edz, eov;
      int qi, ri, elat, lat, bn;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 8; b++) begin
            sa = 6'(a);
            sb = 3'(b);
            if (sb == 0) begin
               eq = '0; er = sa[2:0]; edz = 1'b1; eov = 1'b0; elat = 1;
            end else begin
               qi = int'(sa) / int'(sb);
               ri = int'(sa) % int'(sb);
               eq = 6'(qi); er = 3'(ri); edz = 1'b0; eov = (qi > 31); elat = 8;
            end
            do_op(sa, sb, lat, bn);
            total++;
            if (lat !== elat || {bus.quotient, bus.remainder, bus.div_zero, bus.ovf} !== {eq, er, edz, eov}) begin
               bad++;
               $display("FAIL sweep_%0d_%0d got lat=%0d q=%h r=%h dz=%b ovf=%b want lat=%0d q=%h r=%h dz=%b ovf=%b",
                        sa, sb, lat, bus.quotient, bus.remainder, bus.div_zero, bus.ovf,
                        elat, eq, er, edz, eov);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_ovf();
      test_ignore_start();
      test_reset_abort();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
